// File: rtl/gpu_core_pkg.sv
// Shared core-level encodings: scheduler states, fetcher and LSU handshake values.
package gpu_core_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;

    localparam logic [2:0] FETCHED        = 3'b010;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;

endpackage

// File: rtl/min_pc_select.sv
// Masked minimum-PC reduction: lowest PC among live lanes and the lanes sitting on it.
module min_pc_select #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned PC_BITS = 8
) (
    input  logic [LANES*PC_BITS-1:0] pcs,
    input  logic [LANES-1:0]         live,
    output logic [PC_BITS-1:0]       min_pc,
    output logic [LANES-1:0]         match,
    output logic                     any_live
);

    always_comb begin
        min_pc   = '0;
        any_live = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (live[i] && (!any_live || (pcs[i*PC_BITS +: PC_BITS] < min_pc))) begin
                min_pc   = pcs[i*PC_BITS +: PC_BITS];
                any_live = 1'b1;
            end
        end
    end

    // Every live lane parked on the minimum PC reconverges into the next fetch.
    always_comb begin
        match = '0;
        for (int i = 0; i < LANES; i++) begin
            match[i] = live[i] && (pcs[i*PC_BITS +: PC_BITS] == min_pc);
        end
    end

endmodule

// File: rtl/divergent_scheduler.sv
// Per-block scheduler with per-lane PCs; diverged lanes reconverge on the lowest PC.
module divergent_scheduler
    import gpu_core_pkg::*;
#(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    input  logic                                   decoded_mem_read_enable,
    input  logic                                   decoded_mem_write_enable,
    input  logic                                   decoded_ret,
    input  logic [2:0]                             fetcher_state,
    input  logic [THREADS_PER_BLOCK*2-1:0]         lsu_state,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0]   next_pc,
    output logic [PC_BITS-1:0]                     current_pc,
    output logic [THREADS_PER_BLOCK-1:0]           thread_enable,
    output logic [2:0]                             core_state,
    output logic                                   done
);

    localparam int unsigned T = THREADS_PER_BLOCK;

    core_state_t          state, state_d;
    logic [PC_BITS-1:0]   pc_d;
    logic [T-1:0]         en_d;
    logic                 done_d;
    logic [T*PC_BITS-1:0] thread_pc, thread_pc_d, upd_pc;
    logic [T-1:0]         finished, finished_d, upd_fin;
    logic [T-1:0]         lane_valid, lane_valid_d;
    logic [T-1:0]         launch_mask, upd_live, min_match;
    logic [PC_BITS-1:0]   min_pc;
    logic                 any_live;
    logic                 lsu_busy;

    assign core_state = state;

    // Lanes below thread_count, captured only at launch.
    always_comb begin
        launch_mask = '0;
        for (int i = 0; i < T; i++) begin
            launch_mask[i] = i < int'(thread_count);
        end
    end

    // Retire or advance the enabled lanes; feeds the reduction during UPDATE.
    always_comb begin
        upd_pc  = thread_pc;
        upd_fin = finished;
        for (int i = 0; i < T; i++) begin
            if (thread_enable[i]) begin
                if (decoded_ret) begin
                    upd_fin[i] = 1'b1;
                end else begin
                    upd_pc[i*PC_BITS +: PC_BITS] = next_pc[i*PC_BITS +: PC_BITS];
                end
            end
        end
        upd_live = lane_valid & ~upd_fin;
    end

    always_comb begin
        lsu_busy = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (thread_enable[i] &&
                ((lsu_state[i*2 +: 2] == LSU_REQUESTING) ||
                 (lsu_state[i*2 +: 2] == LSU_WAITING))) begin
                lsu_busy = 1'b1;
            end
        end
    end

    min_pc_select #(
        .LANES   (T),
        .PC_BITS (PC_BITS)
    ) u_min_pc_select (
        .pcs      (upd_pc),
        .live     (upd_live),
        .min_pc   (min_pc),
        .match    (min_match),
        .any_live (any_live)
    );

    always_comb begin
        state_d      = state;
        pc_d         = current_pc;
        en_d         = thread_enable;
        done_d       = done;
        thread_pc_d  = thread_pc;
        finished_d   = finished;
        lane_valid_d = lane_valid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (thread_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        en_d    = '0;
                    end else begin
                        state_d      = FETCH;
                        pc_d         = '0;
                        thread_pc_d  = '0;
                        finished_d   = '0;
                        lane_valid_d = launch_mask;
                        en_d         = launch_mask;
                    end
                end
            end
            FETCH: begin
                if (fetcher_state == FETCHED) state_d = DECODE;
            end
            DECODE: begin
                state_d = (decoded_mem_read_enable || decoded_mem_write_enable) ? REQUEST : EXECUTE;
            end
            REQUEST: state_d = WAIT;
            WAIT: begin
                if (!lsu_busy) state_d = EXECUTE;
            end
            EXECUTE: state_d = UPDATE;
            UPDATE: begin
                thread_pc_d = upd_pc;
                finished_d  = upd_fin;
                if (any_live) begin
                    state_d = FETCH;
                    pc_d    = min_pc;
                    en_d    = min_match;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    en_d    = '0;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            current_pc    <= '0;
            thread_enable <= '0;
            done          <= 1'b0;
            thread_pc     <= '0;
            finished      <= '0;
            lane_valid    <= '0;
        end else begin
            state         <= state_d;
            current_pc    <= pc_d;
            thread_enable <= en_d;
            done          <= done_d;
            thread_pc     <= thread_pc_d;
            finished      <= finished_d;
            lane_valid    <= lane_valid_d;
        end
    end

endmodule

// File: tb/tb_divergent_scheduler.sv
// Bench for divergent_scheduler: vector table, directed divergence/memory sequences, random vs model.
module tb_divergent_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, rd, wr, ret;
    logic [2:0]  tc, fe;
    logic [7:0]  lsu;
    logic [31:0] npc;
    logic [7:0]  current_pc;
    logic [3:0]  thread_enable;
    logic [2:0]  core_state;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divergent_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .thread_count             (tc),
        .decoded_mem_read_enable  (rd),
        .decoded_mem_write_enable (wr),
        .decoded_ret              (ret),
        .fetcher_state            (fe),
        .lsu_state                (lsu),
        .next_pc                  (npc),
        .current_pc               (current_pc),
        .thread_enable            (thread_enable),
        .core_state               (core_state),
        .done                     (done)
    );

    // Behavioural model: plain per-thread arrays plus a state number.
    int         m_state;
    logic [7:0] m_pc;
    logic [3:0] m_en;
    logic       m_done;
    logic [7:0] m_tpc [4];
    logic       m_fin [4];
    logic       m_val [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       found;
        logic [7:0] mn;
        logic       busy;
        if (reset) begin
            m_state = 0; m_pc = 0; m_en = 0; m_done = 0;
            for (int i = 0; i < 4; i++) begin m_tpc[i] = 0; m_fin[i] = 0; m_val[i] = 0; end
            return;
        end
        case (m_state)
            0: if (start) begin
                if (tc == 3'd0) begin
                    m_state = 7; m_done = 1; m_en = 0;
                end else begin
                    m_pc = 0; m_state = 1;
                    for (int i = 0; i < 4; i++) begin
                        m_tpc[i] = 0; m_fin[i] = 0; m_val[i] = i < int'(tc); m_en[i] = m_val[i];
                    end
                end
            end
            1: if (fe == 3'b010) m_state = 2;
            2: m_state = (rd || wr) ? 3 : 5;
            3: m_state = 4;
            4: begin
                busy = 0;
                for (int i = 0; i < 4; i++)
                    if (m_en[i] && (lsu[i*2 +: 2] == 2'b01 || lsu[i*2 +: 2] == 2'b10)) busy = 1;
                if (!busy) m_state = 5;
            end
            5: m_state = 6;
            6: begin
                for (int i = 0; i < 4; i++)
                    if (m_en[i]) begin
                        if (ret) m_fin[i] = 1; else m_tpc[i] = npc[i*8 +: 8];
                    end
                found = 0; mn = 0;
                for (int i = 0; i < 4; i++)
                    if (m_val[i] && !m_fin[i] && (!found || m_tpc[i] < mn)) begin
                        mn = m_tpc[i]; found = 1;
                    end
                if (!found) begin
                    m_state = 7; m_done = 1; m_en = 0;
                end else begin
                    m_pc = mn; m_state = 1;
                    for (int i = 0; i < 4; i++) m_en[i] = m_val[i] && !m_fin[i] && (m_tpc[i] == mn);
                end
            end
            default: if (!start) begin m_state = 0; m_done = 0; end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".state"}, 32'(core_state), 32'(m_state));
        chk({tag, ".pc"},    32'(current_pc), 32'(m_pc));
        chk({tag, ".en"},    32'(thread_enable), 32'(m_en));
        chk({tag, ".done"},  32'(done), 32'(m_done));
    endtask

    task automatic quiet();
        reset = 0; start = 0; tc = 0; fe = 0; rd = 0; wr = 0; ret = 0; lsu = 0; npc = 0;
    endtask

    task automatic launch(input logic [2:0] count);
        quiet(); reset = 1; cyc(); cmp_model("rst");
        reset = 0; start = 1; tc = count; cyc(); cmp_model("launch");
    endtask

    function automatic logic [7:0] prog_npc(input int prog, input int lane, input logic [7:0] pc);
        if (prog == 1 && pc == 8'd1) return (lane < 2) ? 8'd5 : 8'd2;
        return pc + 8'd1;
    endfunction

    function automatic logic prog_ret(input int prog, input logic [7:0] pc);
        case (prog)
            0:       return pc == 8'd3;
            1:       return pc == 8'd2 || pc == 8'd5;
            default: return pc == 8'd1;
        endcase
    endfunction

    logic [7:0] vpc [$];
    logic [3:0] ven [$];
    int         wait_len, after_wait;

    // Runs one small program to completion, recording (pc, mask) on every FETCH entry.
    task automatic run_prog(input int prog, input int bound);
        int prev;
        vpc.delete(); ven.delete();
        wait_len = 0; after_wait = -1; prev = 0;
        vpc.push_back(current_pc); ven.push_back(thread_enable);
        for (int c = 0; c < bound && m_state != 7; c++) begin
            fe  = 3'b010;
            rd  = (prog == 2) && (m_pc == 8'd0);
            ret = prog_ret(prog, m_pc);
            for (int l = 0; l < 4; l++) npc[l*8 +: 8] = prog_npc(prog, l, m_pc);
            lsu = (prog == 2 && m_state == 4 && wait_len < 5) ? 8'b0010_0000 : 8'h00;
            prev = m_state;
            cyc();
            cmp_model($sformatf("p%0d", prog));
            if (core_state == 3'd4) wait_len++;
            if (prev == 4 && core_state != 3'd4) after_wait = int'(core_state);
            if (core_state == 3'd1 && prev != 1) begin
                vpc.push_back(current_pc); ven.push_back(thread_enable);
            end
        end
        chk($sformatf("p%0d.finished", prog), 32'(done), 32'd1);
    endtask

    typedef struct {
        logic rst; logic st; logic [2:0] tc; logic [2:0] fe;
        logic rd; logic wr; logic ret; logic [7:0] lsu; logic [31:0] npc;
        logic [2:0] es; logic [7:0] epc; logic [3:0] een; logic ed;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic r, input logic s, input logic [2:0] t, input logic [2:0] f,
                                input logic a, input logic b, input logic c, input logic [7:0] l,
                                input logic [31:0] n, input logic [2:0] es, input logic [7:0] epc,
                                input logic [3:0] een, input logic ed);
        vec_t v;
        v.rst = r; v.st = s; v.tc = t; v.fe = f; v.rd = a; v.wr = b; v.ret = c; v.lsu = l; v.npc = n;
        v.es = es; v.epc = epc; v.een = een; v.ed = ed;
        return v;
    endfunction

    initial begin #2000000; $display("FAIL watchdog: simulation exceeded time limit"); $fatal(1); end

    initial begin
        logic [7:0] epc1 [4];
        logic [3:0] een1 [4];
        quiet();
        tbl[0]  = mk(1,0,0,0,0,0,0,8'h00,32'h0,        0,0,4'h0,0);
        tbl[1]  = mk(0,1,0,0,0,0,0,8'h00,32'h0,        7,0,4'h0,1);
        tbl[2]  = mk(0,1,0,0,0,0,0,8'h00,32'h0,        7,0,4'h0,1);
        tbl[3]  = mk(0,0,0,0,0,0,0,8'h00,32'h0,        0,0,4'h0,0);
        tbl[4]  = mk(0,1,4,0,0,0,0,8'h00,32'h0,        1,0,4'hf,0);
        tbl[5]  = mk(0,1,4,0,0,0,0,8'h00,32'h0,        1,0,4'hf,0);
        tbl[6]  = mk(0,1,4,2,0,0,0,8'h00,32'h0,        2,0,4'hf,0);
        tbl[7]  = mk(0,1,4,0,1,0,0,8'h00,32'h0,        3,0,4'hf,0);
        tbl[8]  = mk(0,1,4,0,0,0,0,8'h00,32'h0,        4,0,4'hf,0);
        tbl[9]  = mk(0,1,4,0,0,0,0,8'h01,32'h0,        4,0,4'hf,0);
        tbl[10] = mk(0,1,4,0,0,0,0,8'h80,32'h0,        4,0,4'hf,0);
        tbl[11] = mk(0,1,4,0,0,0,0,8'h00,32'h0,        5,0,4'hf,0);
        tbl[12] = mk(0,1,4,0,0,0,0,8'h00,32'h0,        6,0,4'hf,0);
        tbl[13] = mk(0,1,4,0,0,0,1,8'h00,32'h0,        7,0,4'h0,1);
        tbl[14] = mk(0,1,4,0,0,0,0,8'h00,32'h0,        7,0,4'h0,1);
        tbl[15] = mk(1,1,4,0,0,0,0,8'h00,32'h0,        0,0,4'h0,0);
        tbl[16] = mk(0,1,2,0,0,0,0,8'h00,32'h0,        1,0,4'h3,0);
        tbl[17] = mk(0,1,4,2,0,0,0,8'h00,32'h0,        2,0,4'h3,0);
        tbl[18] = mk(0,1,4,0,0,1,0,8'h00,32'h0,        3,0,4'h3,0);
        tbl[19] = mk(0,1,4,0,0,0,0,8'h50,32'h0,        4,0,4'h3,0);
        tbl[20] = mk(0,1,4,0,0,0,0,8'h50,32'h0,        5,0,4'h3,0);
        tbl[21] = mk(0,1,4,0,0,0,0,8'h50,32'h0,        6,0,4'h3,0);
        tbl[22] = mk(0,1,4,0,0,0,0,8'h50,32'h07070707, 1,7,4'h3,0);

        for (int k = 0; k < 23; k++) begin
            reset = tbl[k].rst; start = tbl[k].st; tc = tbl[k].tc; fe = tbl[k].fe;
            rd = tbl[k].rd; wr = tbl[k].wr; ret = tbl[k].ret; lsu = tbl[k].lsu; npc = tbl[k].npc;
            cyc();
            chk($sformatf("vec%0d.state", k), 32'(core_state), 32'(tbl[k].es));
            chk($sformatf("vec%0d.pc", k),    32'(current_pc), 32'(tbl[k].epc));
            chk($sformatf("vec%0d.en", k),    32'(thread_enable), 32'(tbl[k].een));
            chk($sformatf("vec%0d.done", k),  32'(done), 32'(tbl[k].ed));
        end

        // Straight-line program, RET at pc 3.
        launch(3'd4);
        run_prog(0, 100);
        chk("p0.visits", 32'(vpc.size()), 32'd4);
        for (int k = 0; k < 4 && k < vpc.size(); k++) begin
            chk($sformatf("p0.pc%0d", k), 32'(vpc[k]), 32'(k));
            chk($sformatf("p0.en%0d", k), 32'(ven[k]), 32'hf);
        end
        chk("p0.final_pc", 32'(current_pc), 32'd3);
        chk("p0.final_en", 32'(thread_enable), 32'd0);

        // Divergence at pc 1, low group first, then reconverge on the other.
        epc1[0] = 8'd0; epc1[1] = 8'd1; epc1[2] = 8'd2; epc1[3] = 8'd5;
        een1[0] = 4'hf; een1[1] = 4'hf; een1[2] = 4'b1100; een1[3] = 4'b0011;
        launch(3'd4);
        run_prog(1, 100);
        chk("p1.visits", 32'(vpc.size()), 32'd4);
        for (int k = 0; k < 4 && k < vpc.size(); k++) begin
            chk($sformatf("p1.pc%0d", k), 32'(vpc[k]), 32'(epc1[k]));
            chk($sformatf("p1.en%0d", k), 32'(ven[k]), 32'(een1[k]));
        end
        chk("p1.final_pc", 32'(current_pc), 32'd5);

        // Load at pc 0 with lane 2 WAITING for 5 cycles.
        launch(3'd4);
        run_prog(2, 100);
        chk("p2.wait_len", 32'(wait_len), 32'd5);
        chk("p2.after_wait", 32'(after_wait), 32'd5);
        chk("p2.visits", 32'(vpc.size()), 32'd2);

        // Reset mid-WAIT, zero-thread launch, relaunch.
        launch(3'd4);
        fe = 3'b010; rd = 1; lsu = 8'h01;
        for (int c = 0; c < 10 && m_state != 4; c++) begin cyc(); cmp_model("toward_wait"); end
        cyc(); cmp_model("in_wait");
        chk("wait.held", 32'(core_state), 32'd4);
        reset = 1; cyc();
        chk("rst_wait.state", 32'(core_state), 32'd0);
        chk("rst_wait.pc", 32'(current_pc), 32'd0);
        chk("rst_wait.en", 32'(thread_enable), 32'd0);
        chk("rst_wait.done", 32'(done), 32'd0);
        quiet(); start = 1; tc = 3'd0; cyc();
        chk("zero_tc.state", 32'(core_state), 32'd7);
        chk("zero_tc.done", 32'(done), 32'd1);
        start = 0; cyc();
        chk("relaunch.idle", 32'(core_state), 32'd0);
        chk("relaunch.done0", 32'(done), 32'd0);
        start = 1; tc = 3'd4; cyc();
        chk("relaunch.pc", 32'(current_pc), 32'd0);
        chk("relaunch.en", 32'(thread_enable), 32'hf);
        cmp_model("relaunch");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) != 0);
            tc    = 3'($urandom_range(0, 7));
            fe    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            rd    = ($urandom_range(0, 3) == 0);
            wr    = ($urandom_range(0, 3) == 0);
            ret   = ($urandom_range(0, 3) == 0);
            lsu   = 8'($urandom);
            for (int l = 0; l < 4; l++) npc[l*8 +: 8] = 8'($urandom_range(0, 15));
            cyc();
            cmp_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
